// File: rtl/riscv_alu.sv
// 32-bit RV32 ALU: combinational result/zero/carry/overflow, plus a registered result/zero copy (1-cycle latency).
// No handshake: combinational outputs are always valid and the register captures every clock edge.
module riscv_alu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [2:0]  alucontrol,
  output logic [31:0] aluresult,
  output logic        zero,
  output logic        carry,
  output logic        overflow,
  output logic [31:0] aluresult_q,
  output logic        zero_q
);

  logic        sub;
  logic        addsub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        ovf_raw;
  logic        lt;

  // One shared adder; SLT reuses the subtract path.
  assign sub    = (alucontrol == 3'b110) || (alucontrol == 3'b111);
  assign addsub = (alucontrol == 3'b010) || (alucontrol == 3'b110);
  assign b_eff  = sub ? ~srcb : srcb;
  assign sum    = {1'b0, srca} + {1'b0, b_eff} + {32'b0, sub};

  assign ovf_raw = (srca[31] == b_eff[31]) && (sum[31] != srca[31]);
  assign lt      = sum[31] ^ ovf_raw;

  always_comb begin
    aluresult = 32'h0;
    case (alucontrol)
      3'b000:  aluresult = srca & srcb;
      3'b001:  aluresult = srca | srcb;
      3'b010:  aluresult = sum[31:0];
      3'b011:  aluresult = srca ^ srcb;
      3'b100:  aluresult = srca & ~srcb;
      3'b101:  aluresult = srca | ~srcb;
      3'b110:  aluresult = sum[31:0];
      3'b111:  aluresult = {31'b0, lt};
      default: aluresult = 32'h0;
    endcase
  end

  assign zero     = (aluresult == 32'h0);
  assign carry    = addsub ? sum[32] : 1'b0;
  assign overflow = addsub ? ovf_raw : 1'b0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      aluresult_q <= 32'h0;
      zero_q      <= 1'b0;
    end else begin
      aluresult_q <= aluresult;
      zero_q      <= zero;
    end
  end

endmodule

// File: tb/tb_riscv_alu.sv
// Directed-vector bench for riscv_alu; expectations queued at issue, checked by an independent monitor.
module tb_riscv_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] srca, srcb;
  logic [2:0]  alucontrol;
  logic [31:0] aluresult, aluresult_q;
  logic        zero, carry, overflow, zero_q;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_reg;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];

  riscv_alu dut (
    .clk(clk), .reset_n(reset_n), .srca(srca), .srcb(srcb), .alucontrol(alucontrol),
    .aluresult(aluresult), .zero(zero), .carry(carry), .overflow(overflow),
    .aluresult_q(aluresult_q), .zero_q(zero_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (srca=0x%08h srcb=0x%08h ctl=%0d)",
               name, act, req, srca, srcb, alucontrol);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the capturing edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.is_reg) begin
        chk("aluresult_q", aluresult_q, e.res);
        chk("zero_q", {31'b0, zero_q}, {31'b0, e.z});
      end else begin
        chk("aluresult", aluresult, e.res);
        chk("zero", {31'b0, zero}, {31'b0, e.z});
        chk("carry", {31'b0, carry}, {31'b0, e.c});
        chk("overflow", {31'b0, overflow}, {31'b0, e.o});
      end
    end
  end

  task automatic vec(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl,
                     input logic [31:0] res, input logic z, input logic c, input logic o);
    @(posedge clk);
    #1;
    srca = a; srcb = b; alucontrol = ctl;
    sb.push_back('{is_reg: 1'b0, res: res, z: z, c: c, o: o});
  endtask

  task automatic expect_reg(input logic [31:0] res, input logic z);
    sb.push_back('{is_reg: 1'b1, res: res, z: z, c: 1'b0, o: 1'b0});
  endtask

  initial begin
    reset_n = 1'b0; srca = 32'h0; srcb = 32'h0; alucontrol = 3'b000;

    // Reset held: combinational path live, registers cleared.
    vec(32'd25, 32'd21, 3'b010, 32'd46, 1'b0, 1'b0, 1'b0);
    expect_reg(32'h0, 1'b0);
    @(posedge clk); #1;
    sb.push_back('{is_reg: 1'b0, res: 32'd46, z: 1'b0, c: 1'b0, o: 1'b0});
    expect_reg(32'h0, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    expect_reg(32'd46, 1'b0);

    vec(-32'sd24, 32'd285, 3'b111, 32'd1, 1'b0, 1'b0, 1'b0);
    vec(32'd285, -32'sd24, 3'b111, 32'd0, 1'b1, 1'b0, 1'b0);
    vec(32'h7FFFFFFF, 32'd1, 3'b010, 32'h80000000, 1'b0, 1'b0, 1'b1);
    vec(32'hFFFFFFFF, 32'd1, 3'b010, 32'h0, 1'b1, 1'b1, 1'b0);
    vec(32'd11, 32'd42, 3'b110, 32'hFFFFFFE1, 1'b0, 1'b0, 1'b0);
    vec(32'd5, 32'd5, 3'b110, 32'h0, 1'b1, 1'b1, 1'b0);
    vec(32'h80000000, 32'd1, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
    vec(32'h80000000, 32'h7FFFFFFF, 3'b111, 32'd1, 1'b0, 1'b0, 1'b0);
    vec(32'h7FFFFFFF, 32'h80000000, 3'b111, 32'd0, 1'b1, 1'b0, 1'b0);
    vec(32'hF0, 32'hC3, 3'b000, 32'hC0, 1'b0, 1'b0, 1'b0);
    vec(32'hCC, 32'hCA, 3'b001, 32'hCE, 1'b0, 1'b0, 1'b0);
    vec(32'hCC, 32'hCA, 3'b011, 32'h06, 1'b0, 1'b0, 1'b0);
    vec(32'hF0, 32'hC3, 3'b100, 32'h30, 1'b0, 1'b0, 1'b0);
    vec(32'h0000000F, 32'hFFFFFFF0, 3'b101, 32'h0000000F, 1'b0, 1'b0, 1'b0);
    vec(32'hF0, 32'h0F, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0);

    // Held inputs: register captures the zero result and flag.
    @(posedge clk); #1;
    expect_reg(32'h0, 1'b1);

    // Mid-run reset clears registers on the next edge only.
    vec(32'd25, 32'd21, 3'b010, 32'd46, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    expect_reg(32'd46, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    expect_reg(32'h0, 1'b0);
    sb.push_back('{is_reg: 1'b0, res: 32'd46, z: 1'b0, c: 1'b0, o: 1'b0});

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
